// File: rtl/vmem_term_ctrl.sv
// vmem_term_ctrl: keyboard-to-text-buffer write sequencer with cursor tracking and clear sweep.
// Optional feature macro: TERM_BACKSPACE_EN (0x08 erases the cell before the cursor).
`default_nettype none

module vmem_term_ctrl #(
   parameter int COLS = 70,
   parameter int ROWS = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  key_in,
   input  logic        key_valid,
   output logic        key_ready,
   input  logic        clr_req,
   output logic        mem_we,
   output logic [11:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic [6:0]  cur_x,
   output logic [4:0]  cur_y,
   output logic        busy
);

   localparam logic [6:0] XMAX = 7'(COLS - 1);
   localparam logic [4:0] YMAX = 5'(ROWS - 1);

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [6:0]  sx_q, sx_d, cx_q, cx_d;
   logic [4:0]  sy_q, sy_d, cy_q, cy_d;
   logic        last_q, last_d;
   logic        full_q, full_d;
   logic        we_q, we_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic [11:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        sweep;
   logic        accept;
   logic        printable;

   assign accept    = key_valid && ready_q;
   assign printable = (key_in >= 8'h20) && (key_in <= 8'h7E);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         sx_q    <= '0;
         sy_q    <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
         last_q  <= 1'b0;
         full_q  <= 1'b0;
         we_q    <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b1;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         last_q  <= last_d;
         full_q  <= full_d;
         we_q    <= we_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // state_q names the phase whose outputs are visible this cycle; the sweep
   // counters always hold the next cell to clear and rest at (0,0) outside CLEAR.
   always_comb begin
      state_d = state_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      last_d  = 1'b0;
      full_d  = full_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ready_d = 1'b0;
      busy_d  = 1'b1;
      sweep   = 1'b0;

      case (state_q)
         ST_CLEAR: begin
            if (last_q) begin
               state_d = ST_IDLE;
               ready_d = 1'b1;
               busy_d  = 1'b0;
            end else begin
               sweep = 1'b1;
            end
         end

         ST_IDLE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            if (clr_req) begin
               sweep = 1'b1;
            end else if (accept) begin
               if (printable) begin
                  state_d = ST_WRITE;
                  we_d    = 1'b1;
                  addr_d  = {cx_q, cy_q};
                  wdata_d = key_in;
                  ready_d = 1'b0;
                  busy_d  = 1'b1;
                  if (cx_q == XMAX) begin
                     cx_d = '0;
                     if (cy_q == YMAX) begin
                        cy_d   = '0;
                        full_d = 1'b1;
                     end else begin
                        cy_d = cy_q + 5'd1;
                     end
                  end else begin
                     cx_d = cx_q + 7'd1;
                  end
               end else if (key_in == 8'h0A) begin
                  cx_d = '0;
                  if (cy_q == YMAX) begin
                     sweep = 1'b1;
                  end else begin
                     cy_d = cy_q + 5'd1;
                  end
               end
`ifdef TERM_BACKSPACE_EN
               else if ((key_in == 8'h08) && ((cx_q != '0) || (cy_q != '0))) begin
                  state_d = ST_WRITE;
                  we_d    = 1'b1;
                  wdata_d = 8'h00;
                  ready_d = 1'b0;
                  busy_d  = 1'b1;
                  if (cx_q != '0) begin
                     cx_d = cx_q - 7'd1;
                  end else begin
                     cx_d = XMAX;
                     cy_d = cy_q - 5'd1;
                  end
                  addr_d = {cx_d, cy_d};
               end
`endif
            end
         end

         ST_WRITE: begin
            if (full_q) begin
               sweep = 1'b1;
            end else begin
               state_d = ST_IDLE;
               ready_d = 1'b1;
               busy_d  = 1'b0;
            end
         end

         default: sweep = 1'b1;
      endcase

      // One clear cycle: write the pending cell and step x-fastest.
      if (sweep) begin
         state_d = ST_CLEAR;
         we_d    = 1'b1;
         addr_d  = {sx_q, sy_q};
         wdata_d = 8'h00;
         ready_d = 1'b0;
         busy_d  = 1'b1;
         cx_d    = '0;
         cy_d    = '0;
         full_d  = 1'b0;
         if (sx_q == XMAX) begin
            sx_d = '0;
            if (sy_q == YMAX) begin
               sy_d   = '0;
               last_d = 1'b1;
            end else begin
               sy_d = sy_q + 5'd1;
            end
         end else begin
            sx_d = sx_q + 7'd1;
         end
      end
   end

   assign key_ready = ready_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cur_x     = cx_q;
   assign cur_y     = cy_q;
   assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_vmem_term_ctrl.sv
// Self-checking bench for vmem_term_ctrl: directed scenarios plus random keys
// checked against a linear-position cursor model.
`default_nettype none

module tb_vmem_term_ctrl;

   localparam int COLS  = 70;
   localparam int ROWS  = 30;
   localparam int CELLS = COLS * ROWS;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  key_in = 8'h00;
   logic        key_valid = 1'b0;
   logic        clr_req = 1'b0;
   logic        key_ready;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [6:0]  cur_x;
   logic [4:0]  cur_y;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;
   int mx = 0;
   int my = 0;

   always #5 clk = ~clk;

   vmem_term_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clk       (clk),
      .reset     (reset),
      .key_in    (key_in),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .clr_req   (clr_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cur_x     (cur_x),
      .cur_y     (cur_y),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_we"},    mem_we, 0);
      check({tag, "_addr"},  mem_addr, 0);
      check({tag, "_wdata"}, mem_wdata, 0);
      check({tag, "_ready"}, key_ready, 0);
      check({tag, "_busy"},  busy, 1);
      check({tag, "_curx"},  cur_x, 0);
      check({tag, "_cury"},  cur_y, 0);
   endtask

   // Called at the sample point showing the first clear write; returns at the
   // sample point of the first idle cycle.
   task automatic check_clear();
      int          bad;
      logic [11:0] ea;
      logic [11:0] first_a;
      logic [11:0] last_a;
      bad     = 0;
      first_a = 12'hfff;
      last_a  = 12'hfff;
      for (int i = 0; i < CELLS; i++) begin
         ea = {7'(i % COLS), 5'(i / COLS)};
         if (i == 0) first_a = mem_addr;
         last_a = mem_addr;
         if (mem_we !== 1'b1 || mem_addr !== ea || mem_wdata !== 8'h00 ||
             busy !== 1'b1 || key_ready !== 1'b0)
            bad++;
         @(negedge clk);
      end
      check("clear_bad_cycles", bad, 0);
      check("clear_first_addr", first_a, 12'h000);
      check("clear_last_addr", last_a, {7'(COLS - 1), 5'(ROWS - 1)});
      check("clear_end_we", mem_we, 0);
      check("clear_end_ready", key_ready, 1);
      check("clear_end_busy", busy, 0);
      check("clear_end_curx", cur_x, 0);
      check("clear_end_cury", cur_y, 0);
      mx = 0;
      my = 0;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (key_ready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", key_ready, 1);
   endtask

   task automatic send_and_check(input logic [7:0] k);
      int          p;
      int          np;
      bit          wr;
      bit          full;
      logic [7:0]  wd;
      logic [11:0] wa;
      wait_ready();
      p    = my * COLS + mx;
      np   = p;
      wr   = 1'b0;
      full = 1'b0;
      wd   = k;
      wa   = 12'h000;
      if (k >= 8'h20 && k <= 8'h7E) begin
         wr = 1'b1;
         wa = {7'(mx), 5'(my)};
         np = p + 1;
         if (np == CELLS) full = 1'b1;
      end else if (k == 8'h0A) begin
         np = (my + 1) * COLS;
         if (my + 1 == ROWS) full = 1'b1;
      end
`ifdef TERM_BACKSPACE_EN
      else if (k == 8'h08 && p > 0) begin
         np = p - 1;
         wr = 1'b1;
         wd = 8'h00;
         wa = {7'(np % COLS), 5'(np / COLS)};
      end
`endif
      key_in    = k;
      key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
      key_in    = 8'($urandom);
      if (wr) begin
         check("wr_we", mem_we, 1);
         check("wr_addr", mem_addr, wa);
         check("wr_data", mem_wdata, wd);
         check("wr_ready", key_ready, 0);
         check("wr_busy", busy, 1);
         if (full) begin
            @(negedge clk);
            check_clear();
         end else begin
            mx = np % COLS;
            my = np / COLS;
            check("wr_curx", cur_x, mx);
            check("wr_cury", cur_y, my);
            @(negedge clk);
            check("post_wr_ready", key_ready, 1);
            check("post_wr_we", mem_we, 0);
         end
      end else if (full) begin
         check_clear();
      end else begin
         mx = np % COLS;
         my = np / COLS;
         check("nowr_we", mem_we, 0);
         check("nowr_ready", key_ready, 1);
         check("nowr_curx", cur_x, mx);
         check("nowr_cury", cur_y, my);
      end
   endtask

   task automatic send_printable();
      logic [7:0] k;
      k = 8'h20 + 8'($urandom_range(0, 94));
      send_and_check(k);
   endtask

   initial begin
      logic [7:0] k;
      int         r;

      // Power-up reset and initial sweep
      reset = 1'b1;
      @(negedge clk);
      check_reset_values("rst");
      reset = 1'b0;
      @(negedge clk);
      check_clear();

      // First printable key at home position
      send_and_check(8'h41);
      check("t2_curx", cur_x, 1);
      check("t2_cury", cur_y, 0);

      // clr_req beats a simultaneous key; key 0x42 never written
      clr_req   = 1'b1;
      key_valid = 1'b1;
      key_in    = 8'h42;
      @(negedge clk);
      clr_req   = 1'b0;
      key_valid = 1'b0;
      check_clear();

      // Full row of printables wraps to the next row
      for (int i = 0; i < COLS; i++) send_printable();
      check("t3_wrap_curx", cur_x, 0);
      check("t3_wrap_cury", cur_y, 1);
      send_and_check(8'h0A);
      send_and_check(8'h0A);
      for (int i = 0; i < 5; i++) send_printable();
      check("t3_pos_curx", cur_x, 5);
      check("t3_pos_cury", cur_y, 3);
      send_and_check(8'h0A);
      check("t3_enter_curx", cur_x, 0);
      check("t3_enter_cury", cur_y, 4);

      // Last cell written, then screen-full clear
      for (int i = 0; i < ROWS - 5; i++) send_and_check(8'h0A);
      for (int i = 0; i < COLS - 1; i++) send_printable();
      check("t4_last_curx", cur_x, COLS - 1);
      check("t4_last_cury", cur_y, ROWS - 1);
      send_and_check(8'h5A);
      check("t4_after_curx", cur_x, 0);
      check("t4_after_cury", cur_y, 0);

      // Reset in the middle of a requested clear restarts the sweep
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      repeat (50) @(negedge clk);
      check("t5_mid_addr", mem_addr, {7'd50, 5'd0});
      reset = 1'b1;
      @(negedge clk);
      check_reset_values("rst_mid");
      reset = 1'b0;
      @(negedge clk);
      check_clear();

      // Backspace across a row boundary and at home
      send_and_check(8'h0A);
      send_and_check(8'h0A);
      send_and_check(8'h08);
`ifdef TERM_BACKSPACE_EN
      check("t6_bs_curx", cur_x, COLS - 1);
      check("t6_bs_cury", cur_y, 1);
`else
      check("t6_bs_curx", cur_x, 0);
      check("t6_bs_cury", cur_y, 2);
`endif
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      check_clear();
      send_and_check(8'h08);
      check("t6_home_curx", cur_x, 0);
      check("t6_home_cury", cur_y, 0);

      // Random key mix against the cursor model
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 50)      k = 8'h20 + 8'($urandom_range(0, 94));
         else if (r < 70) k = 8'h0A;
         else if (r < 85) k = 8'h08;
         else if (r < 93) k = 8'($urandom_range(0, 31));
         else             k = 8'h7F + 8'($urandom_range(0, 128));
         send_and_check(k);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
